alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_seq                                                      |
// | Description : Registered ALU with eight opcodes. Seven complete in one     |
// |               cycle. Multiply is an iterative shift-add over WIDTH cycles. |
// |               Results and flags are registered and marked by a one-cycle   |
// |               done pulse.                                                  |
// | Config      : `define ALU_SEQ_MUL_EN builds the multiplier. Without it,    |
// |               opcode 111 returns 0 and raises illegal.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] dataInACC,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [WIDTH-1:0] pc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic             zero,
  output logic             carry,
  output logic             illegal
);

  localparam int               SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_BNZ  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_illegal;

  // Single-cycle result, computed straight from the inputs present at the start edge
  always_comb begin
    w_res     = '0;
    w_carry   = 1'b0;
    w_illegal = 1'b0;
    case (control)
      OP_ADD:  {w_carry, w_res} = {1'b0, dataInACC} + {1'b0, dataIn};
      OP_NAND: w_res = ~(dataInACC & dataIn);
      OP_BNZ:  w_res = (dataInACC != '0) ? (pc + ONE) : dataIn;
      OP_SLT:  w_res = (dataInACC < dataIn) ? ONE : '0;
      OP_SUB: begin
        w_res   = dataInACC - dataIn;
        w_carry = (dataInACC < dataIn);
      end
      OP_SHL:  w_res = dataInACC << dataIn[SHW-1:0];
      OP_SHR:  w_res = dataInACC >> dataIn[SHW-1:0];
`ifdef ALU_SEQ_MUL_EN
      default: w_res = '0;  // MUL takes the multi-cycle path
`else
      default: w_illegal = 1'b1;
`endif
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               r_busy;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign busy      = r_busy;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: enter MUL on a multiply start, leave after the last step
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && control == OP_MUL) state_d = S_MUL;
      S_MUL:   if (r_cnt == CNT_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: single-cycle writeback, multiplier load and shift-add steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOut  <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      illegal  <= 1'b0;
      done     <= 1'b0;
      r_busy   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (state_q == S_IDLE) begin
        if (start) begin
          if (control == OP_MUL) begin
            r_mcand  <= {{WIDTH{1'b0}}, dataInACC};
            r_mplier <= dataIn;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end else begin
            dataOut <= w_res;
            zero    <= (w_res == '0);
            carry   <= w_carry;
            illegal <= w_illegal;
            done    <= 1'b1;
          end
        end
      end else begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_ONE;
        if (r_cnt == CNT_LAST) begin
          dataOut <= w_acc_nxt[WIDTH-1:0];
          zero    <= (w_acc_nxt[WIDTH-1:0] == '0);
          carry   <= (w_acc_nxt[2*WIDTH-1:WIDTH] != '0);
          illegal <= 1'b0;
          done    <= 1'b1;
          r_busy  <= 1'b0;
        end
      end
    end
  end
`else
  assign busy = 1'b0;

  // Datapath: every opcode, including the unsupported MUL, completes in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOut <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      illegal <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dataOut <= w_res;
        zero    <= (w_res == '0);
        carry   <= w_carry;
        illegal <= w_illegal;
        done    <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_seq                                                   |
// | Description : Directed self-checking bench for alu_seq (WIDTH=8).          |
// |               The multiply section follows ALU_SEQ_MUL_EN.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       control;
  logic [WIDTH-1:0] dataInACC;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] pc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dataOut;
  logic             zero;
  logic             carry;
  logic             illegal;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .control   (control),
    .dataInACC (dataInACC),
    .dataIn    (dataIn),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .dataOut   (dataOut),
    .zero      (zero),
    .carry     (carry),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] p);
    start     = 1'b1;
    control   = c;
    dataInACC = a;
    dataIn    = b;
    pc        = p;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; control = 3'b000;
    dataInACC = '0; dataIn = '0; pc = '0;

    // Reset state
    tick(); tick();
    chk("rst_dataOut", dataOut, 0);
    chk("rst_zero",    zero,    0);
    chk("rst_carry",   carry,   0);
    chk("rst_illegal", illegal, 0);
    chk("rst_done",    done,    0);
    chk("rst_busy",    busy,    0);
    rst_n = 1'b1;
    tick();

    // ADD 200+100 = 300 -> 44 with carry
    op(3'b000, 8'd200, 8'd100, 8'h00);
    tick();
    start = 1'b0;
    chk("add_dataOut", dataOut, 44);
    chk("add_carry",   carry,   1);
    chk("add_zero",    zero,    0);
    chk("add_done",    done,    1);
    chk("add_illegal", illegal, 0);
    dataInACC = 8'h11;  // later input changes must not disturb the held result
    tick();
    chk("add_done_drop", done,    0);
    chk("add_hold",      dataOut, 44);

    // SUB 5-7 = 254 with borrow, then back-to-back NAND FF,FF = 0
    op(3'b100, 8'd5, 8'd7, 8'h00);
    tick();
    chk("sub_dataOut", dataOut, 254);
    chk("sub_carry",   carry,   1);
    op(3'b001, 8'hFF, 8'hFF, 8'h00);
    tick();
    chk("nand_dataOut", dataOut, 0);
    chk("nand_zero",    zero,    1);
    chk("nand_carry",   carry,   0);
    chk("nand_done",    done,    1);

    // BNZ taken with pc wrap, then not taken
    op(3'b010, 8'd3, 8'h40, 8'hFF);
    tick();
    chk("bnz_wrap",      dataOut, 8'h00);
    chk("bnz_wrap_zero", zero,    1);
    op(3'b010, 8'd0, 8'h40, 8'hFF);
    tick();
    chk("bnz_fall",      dataOut, 8'h40);
    chk("bnz_fall_zero", zero,    0);

    // SLT, SHL, SHR
    op(3'b011, 8'd3, 8'd9, 8'h00);
    tick();
    chk("slt_lt", dataOut, 1);
    op(3'b011, 8'd9, 8'd3, 8'h00);
    tick();
    chk("slt_ge", dataOut, 0);
    op(3'b101, 8'h81, 8'd3, 8'h00);
    tick();
    chk("shl_dataOut", dataOut, 8'h08);
    chk("shl_carry",   carry,   0);
    op(3'b110, 8'h80, 8'h0F, 8'h00);  // amount uses only B[2:0] = 7
    tick();
    start = 1'b0;
    chk("shr_dataOut", dataOut, 8'h01);
    tick();
    chk("idle_done", done,    0);
    chk("idle_hold", dataOut, 8'h01);

`ifdef ALU_SEQ_MUL_EN
    // MUL 15*17 = 255, busy for 8 cycles, with a dropped start in the middle
    op(3'b111, 8'd15, 8'd17, 8'h00);
    tick();
    start = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      chk($sformatf("mul_busy_%0d", i), busy, 1);
      chk($sformatf("mul_nodone_%0d", i), done, 0);
      if (i == 3) op(3'b000, 8'd1, 8'd1, 8'h00);
      if (i == 4) start = 1'b0;
      tick();
    end
    chk("mul_busy_end", busy,    0);
    chk("mul_done",     done,    1);
    chk("mul_dataOut",  dataOut, 255);
    chk("mul_carry",    carry,   0);
    chk("mul_zero",     zero,    0);
    chk("mul_illegal",  illegal, 0);
    tick();
    chk("mul_done_drop", done, 0);

    // MUL 16*16 = 256 -> low 0, overflow
    op(3'b111, 8'd16, 8'd16, 8'h00);
    tick();
    start = 1'b0;
    repeat (WIDTH) tick();
    chk("mul2_done",    done,    1);
    chk("mul2_dataOut", dataOut, 0);
    chk("mul2_carry",   carry,   1);
    chk("mul2_zero",    zero,    1);

    // Reset four cycles into a multiply
    op(3'b111, 8'd15, 8'd17, 8'h00);
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",    busy,    0);
    chk("mid_rst_done",    done,    0);
    chk("mid_rst_dataOut", dataOut, 0);
    chk("mid_rst_carry",   carry,   0);
    chk("mid_rst_zero",    zero,    0);
    tick();
    rst_n = 1'b1;
    op(3'b000, 8'd1, 8'd1, 8'h00);
    tick();
    start = 1'b0;
    chk("post_rst_add", dataOut, 2);
    chk("post_rst_done", done, 1);
    repeat (WIDTH) begin
      tick();
      chk("post_rst_nodone", done, 0);
    end
`else
    // MUL is unsupported: one cycle, zero result, illegal flagged
    op(3'b111, 8'd15, 8'd17, 8'h00);
    tick();
    start = 1'b0;
    chk("nomul_done",    done,    1);
    chk("nomul_dataOut", dataOut, 0);
    chk("nomul_zero",    zero,    1);
    chk("nomul_carry",   carry,   0);
    chk("nomul_illegal", illegal, 1);
    chk("nomul_busy",    busy,    0);
    op(3'b000, 8'd1, 8'd1, 8'h00);
    tick();
    start = 1'b0;
    chk("nomul_add",         dataOut, 2);
    chk("nomul_add_illegal", illegal, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_dataOut", dataOut, 0);
    chk("async_rst_done",    done,    0);
    tick();
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
